// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_rr_arbiter
// Brief    : Packet-granular round-robin arbiter merging NUM_REQ valid/ready
//            streams into one, tagging each beat with its source index.
//            Define STREAM_RR_ARBITER_OUT_REG_EN for a 2-entry output skid.
// Revision : 1.0 - initial release
// ============================================================================
module stream_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ELEM_WIDTH = 8,
    parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          arst_ni,
    input  logic [NUM_REQ*ELEM_WIDTH-1:0] elem_in_i,
    input  logic [NUM_REQ-1:0]            elem_in_last_i,
    input  logic [NUM_REQ-1:0]            elem_in_valid_i,
    output logic [NUM_REQ-1:0]            elem_in_ready_o,
    output logic [ELEM_WIDTH-1:0]         elem_out_o,
    output logic                          elem_out_last_o,
    output logic [IDX_WIDTH-1:0]          elem_out_src_o,
    output logic                          elem_out_valid_o,
    input  logic                          elem_out_ready_i
);

    localparam int c_pay_width = IDX_WIDTH + 1 + ELEM_WIDTH;

    // (a + b) mod NUM_REQ for a, b < NUM_REQ; one extra bit holds the carry.
    function automatic logic [IDX_WIDTH-1:0] f_wrap_add(
        input logic [IDX_WIDTH-1:0] a,
        input logic [IDX_WIDTH-1:0] b
    );
        logic [IDX_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (IDX_WIDTH+1)'(NUM_REQ)) begin
            sum = sum - (IDX_WIDTH+1)'(NUM_REQ);
        end
        return sum[IDX_WIDTH-1:0];
    endfunction

    logic [IDX_WIDTH-1:0]   r_ptr;
    logic                   r_locked;
    logic [IDX_WIDTH-1:0]   r_lock_idx;

    logic [IDX_WIDTH-1:0]   w_search_idx;
    logic                   w_any_valid;
    logic [IDX_WIDTH-1:0]   w_grant;
    logic                   w_sel_en;
    logic                   w_arb_valid;
    logic                   w_arb_ready;
    logic                   w_arb_last;
    logic [ELEM_WIDTH-1:0]  w_arb_data;
    logic [IDX_WIDTH-1:0]   w_arb_src;
    logic                   w_xfer;
    logic [c_pay_width-1:0] w_arb_pay;

    // Walk offsets from the far end so the smallest offset from r_ptr wins.
    always_comb begin
        logic [IDX_WIDTH-1:0] cand;
        w_search_idx = '0;
        w_any_valid  = 1'b0;
        cand         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = f_wrap_add(r_ptr, IDX_WIDTH'(k));
            if (elem_in_valid_i[cand]) begin
                w_search_idx = cand;
                w_any_valid  = 1'b1;
            end
        end
    end

    assign w_grant     = r_locked ? r_lock_idx : w_search_idx;
    assign w_sel_en    = r_locked | w_any_valid;
    assign w_arb_valid = r_locked ? elem_in_valid_i[r_lock_idx] : w_any_valid;
    assign w_arb_data  = w_sel_en ? elem_in_i[w_grant*ELEM_WIDTH +: ELEM_WIDTH] : '0;
    assign w_arb_last  = w_sel_en & elem_in_last_i[w_grant];
    assign w_arb_src   = w_sel_en ? w_grant : '0;
    assign w_arb_pay   = {w_arb_src, w_arb_last, w_arb_data};
    assign w_xfer      = w_arb_valid & w_arb_ready;

    always_comb begin
        elem_in_ready_o = '0;
        if (w_sel_en) begin
            elem_in_ready_o[w_grant] = w_arb_ready;
        end
    end

    // Any presented beat that does not close its packet locks the grant, so
    // backpressure never lets the arbiter withdraw or switch a visible beat.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_ptr      <= '0;
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_xfer && w_arb_last) begin
            r_locked <= 1'b0;
            r_ptr    <= f_wrap_add(w_grant, IDX_WIDTH'(1));
        end else if (w_arb_valid) begin
            r_locked   <= 1'b1;
            r_lock_idx <= w_grant;
        end
    end

`ifdef STREAM_RR_ARBITER_OUT_REG_EN
    logic                   r_out_valid;
    logic [c_pay_width-1:0] r_out_pay;
    logic                   r_skid_valid;
    logic [c_pay_width-1:0] r_skid_pay;

    // Upstream ready depends only on skid occupancy, cutting the ready path.
    assign w_arb_ready = ~r_skid_valid;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_out_valid  <= 1'b0;
            r_out_pay    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pay   <= '0;
        end else if (w_xfer) begin
            if (r_out_valid && !elem_out_ready_i) begin
                r_skid_valid <= 1'b1;
                r_skid_pay   <= w_arb_pay;
            end else begin
                r_out_valid <= 1'b1;
                r_out_pay   <= w_arb_pay;
            end
        end else if (!r_out_valid || elem_out_ready_i) begin
            r_out_valid  <= r_skid_valid;
            r_skid_valid <= 1'b0;
            if (r_skid_valid) begin
                r_out_pay <= r_skid_pay;
            end
        end
    end

    assign {elem_out_src_o, elem_out_last_o, elem_out_o} = r_out_pay;
    assign elem_out_valid_o = r_out_valid;
`else
    assign w_arb_ready = elem_out_ready_i;
    assign {elem_out_src_o, elem_out_last_o, elem_out_o} = w_arb_pay;
    assign elem_out_valid_o = w_arb_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_rr_arbiter
// Brief    : Self-checking bench for stream_rr_arbiter (4- and 3-way instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int N3 = 3;

    logic           clk = 1'b0;
    logic           rst_n;

    logic [N*W-1:0] d;
    logic [N-1:0]   l, v, in_rdy;
    logic [W-1:0]   od;
    logic           ol, ov, ordy;
    logic [1:0]     os;

    logic [N3*W-1:0] d3;
    logic [N3-1:0]   l3, v3, in_rdy3;
    logic [W-1:0]    od3;
    logic            ol3, ov3, ordy3;
    logic [1:0]      os3;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr;
    int m_owner;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.NUM_REQ(N), .ELEM_WIDTH(W)) dut (
        .clk_i(clk), .arst_ni(rst_n),
        .elem_in_i(d), .elem_in_last_i(l), .elem_in_valid_i(v), .elem_in_ready_o(in_rdy),
        .elem_out_o(od), .elem_out_last_o(ol), .elem_out_src_o(os),
        .elem_out_valid_o(ov), .elem_out_ready_i(ordy)
    );

    stream_rr_arbiter #(.NUM_REQ(N3), .ELEM_WIDTH(W)) dut3 (
        .clk_i(clk), .arst_ni(rst_n),
        .elem_in_i(d3), .elem_in_last_i(l3), .elem_in_valid_i(v3), .elem_in_ready_o(in_rdy3),
        .elem_out_o(od3), .elem_out_last_o(ol3), .elem_out_src_o(os3),
        .elem_out_valid_o(ov3), .elem_out_ready_i(ordy3)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        d = '0; l = '0; v = '0; ordy = 1'b0;
        d3 = '0; l3 = '0; v3 = '0; ordy3 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        m_ptr   = 0;
        m_owner = -1;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        n_checks += 4;
        if (ov !== 1'b0 || ol !== 1'b0) begin n_fail++; $display("FAIL reset_valid_last: got v=%b l=%b expected 0 0", ov, ol); end
        if (od !== 8'h00 || os !== 2'd0) begin n_fail++; $display("FAIL reset_data_src: got d=%h s=%0d expected 00 0", od, os); end
        if (in_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", in_rdy); end
        if (ov3 !== 1'b0 || in_rdy3 !== 3'b000) begin n_fail++; $display("FAIL reset_dut3: got v=%b r=%b expected 0 000", ov3, in_rdy3); end
    endtask

`ifndef STREAM_RR_ARBITER_OUT_REG_EN
    task automatic test_rr_single();
        logic [1:0] exp_src [3] = '{2'd0, 2'd2, 2'd0};
        logic [7:0] exp_dat [3] = '{8'h10, 8'h30, 8'h10};
        int         exp_ptr [3] = '{1, 3, 1};
        do_reset();
        d[0*W +: W] = 8'h10; d[2*W +: W] = 8'h30;
        l = 4'b0101; v = 4'b0101; ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++;
            if (ov !== 1'b1 || os !== exp_src[i] || od !== exp_dat[i]) begin
                n_fail++; $display("FAIL rr_single_out[%0d]: got v=%b s=%0d d=%h expected 1 %0d %h", i, ov, os, od, exp_src[i], exp_dat[i]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (int'(dut.r_ptr) != exp_ptr[i]) begin
                n_fail++; $display("FAIL rr_single_ptr[%0d]: got %0d expected %0d", i, dut.r_ptr, exp_ptr[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lock_packet();
        logic [7:0] pk [3] = '{8'hA1, 8'hA2, 8'hA3};
        do_reset();
        ordy = 1'b1;
        d[3*W +: W] = 8'hD3; l[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v[1] = (i < 3);
            d[1*W +: W] = (i < 3) ? pk[i] : 8'h00;
            l[1] = (i == 2);
            v[3] = (i >= 1);
            #2;
            n_checks++;
            if (i < 3) begin
                if (ov !== 1'b1 || os !== 2'd1 || od !== pk[i] || ol !== (i == 2) || in_rdy !== 4'b0010) begin
                    n_fail++; $display("FAIL lock_beat[%0d]: got v=%b s=%0d d=%h l=%b r=%b expected 1 1 %h %b 0010", i, ov, os, od, ol, in_rdy, pk[i], i == 2);
                end
            end else begin
                if (ov !== 1'b1 || os !== 2'd3 || od !== 8'hD3 || in_rdy !== 4'b1000) begin
                    n_fail++; $display("FAIL lock_next: got v=%b s=%0d d=%h r=%b expected 1 3 d3 1000", ov, os, od, in_rdy);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        v[1] = 1'b1; d[1*W +: W] = 8'h55; l[1] = 1'b1;
        d[0*W +: W] = 8'h0A; l[0] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            v[0] = (i >= 2);
            v[1] = (i < 6);
            ordy = (i >= 5);
            #2;
            n_checks++;
            if (i < 5) begin
                if (ov !== 1'b1 || os !== 2'd1 || od !== 8'h55 || in_rdy !== 4'b0000) begin
                    n_fail++; $display("FAIL bp_hold[%0d]: got v=%b s=%0d d=%h r=%b expected 1 1 55 0000", i, ov, os, od, in_rdy);
                end
            end else if (i == 5) begin
                if (ov !== 1'b1 || os !== 2'd1 || od !== 8'h55 || in_rdy !== 4'b0010) begin
                    n_fail++; $display("FAIL bp_release: got v=%b s=%0d d=%h r=%b expected 1 1 55 0010", ov, os, od, in_rdy);
                end
            end else begin
                if (ov !== 1'b1 || os !== 2'd0 || od !== 8'h0A || in_rdy !== 4'b0001) begin
                    n_fail++; $display("FAIL bp_switch: got v=%b s=%0d d=%h r=%b expected 1 0 0a 0001", ov, os, od, in_rdy);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        d3 = {8'h42, 8'h41, 8'h40}; l3 = 3'b111; v3 = 3'b111; ordy3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            n_checks++;
            if (ov3 !== 1'b1 || int'(os3) != i % 3 || od3 !== 8'(8'h40 + i % 3)) begin
                n_fail++; $display("FAIL wrap[%0d]: got v=%b s=%0d d=%h expected 1 %0d %h", i, ov3, os3, od3, i % 3, 8'h40 + i % 3);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ordy = 1'b1;
        v = 4'b0010; d[1*W +: W] = 8'h01; l = 4'b0010;
        @(negedge clk);
        v = 4'b0100; d[2*W +: W] = 8'hB1; l = 4'b0000;
        #2;
        n_checks++;
        if (ov !== 1'b1 || os !== 2'd2 || od !== 8'hB1) begin
            n_fail++; $display("FAIL mid_beat1: got v=%b s=%0d d=%h expected 1 2 b1", ov, os, od);
        end
        @(negedge clk);
        #2;
        n_checks++;
        if (dut.r_locked !== 1'b1 || dut.r_ptr !== 2'd2) begin
            n_fail++; $display("FAIL mid_prelock: got locked=%b ptr=%0d expected 1 2", dut.r_locked, dut.r_ptr);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut.r_locked !== 1'b0 || dut.r_ptr !== 2'd0) begin
            n_fail++; $display("FAIL mid_async_clear: got locked=%b ptr=%0d expected 0 0", dut.r_locked, dut.r_ptr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        v = 4'b0101; d[0*W +: W] = 8'h0C; l = 4'b0001; d[2*W +: W] = 8'hB2;
        #2;
        n_checks++;
        if (ov !== 1'b1 || os !== 2'd0 || od !== 8'h0C || dut.r_locked !== 1'b0) begin
            n_fail++; $display("FAIL mid_after: got v=%b s=%0d d=%h locked=%b expected 1 0 0c 0", ov, os, od, dut.r_locked);
        end
        @(negedge clk);
    endtask

    // Reference: round-robin owner/pointer bookkeeping over integers.
    task automatic test_random();
        int         rem  [N];
        bit         pres [N];
        int         g;
        logic       ev, el;
        logic [7:0] ed;
        logic [1:0] es;
        logic [3:0] er;
        do_reset();
        for (int r = 0; r < N; r++) begin rem[r] = 0; pres[r] = 1'b0; end
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < N; r++) begin
                if (!pres[r] && $urandom_range(0, 2) != 0) begin
                    pres[r] = 1'b1;
                    if (rem[r] == 0) rem[r] = $urandom_range(1, 4);
                    d[r*W +: W] = 8'($urandom);
                end else if (!pres[r]) begin
                    d[r*W +: W] = 8'($urandom);
                end
                v[r] = pres[r];
                l[r] = pres[r] ? (rem[r] == 1) : 1'($urandom);
            end
            ordy = ($urandom_range(0, 3) != 0);
            #2;
            g = -1;
            if (m_owner >= 0) g = m_owner;
            else for (int k = 0; k < N; k++) if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g < 0) begin
                ev = 1'b0; ed = 8'h00; el = 1'b0; es = 2'd0; er = 4'b0000;
            end else begin
                ev = v[g]; ed = d[g*W +: W]; el = l[g]; es = g[1:0];
                er = ordy ? (4'b0001 << g) : 4'b0000;
            end
            n_checks += 2;
            if (ov !== ev || in_rdy !== er) begin
                n_fail++; $display("FAIL rand_ctl[%0d]: got v=%b r=%b expected %b %b", c, ov, in_rdy, ev, er);
            end
            if (os !== es || od !== ed || ol !== el) begin
                n_fail++; $display("FAIL rand_dat[%0d]: got s=%0d d=%h l=%b expected %0d %h %b", c, os, od, ol, es, ed, el);
            end
            if (ev && ordy) begin
                pres[g] = 1'b0;
                rem[g]  = rem[g] - 1;
            end
            if (ev && ordy && el) begin
                m_owner = -1;
                m_ptr   = (g + 1) % N;
            end else if (ev) begin
                m_owner = g;
            end
            @(negedge clk);
        end
    endtask
`else
    task automatic test_skid();
        int cnt [2];
        int got;
        int src_i;
        logic [1:0] es;
        logic [7:0] ed;
        do_reset();
        cnt[0] = 0; cnt[1] = 0; got = 0;
        v = 4'b0101; l = 4'b0101;
        for (int c = 0; c < 40; c++) begin
            d[0*W +: W] = 8'(8'h10 + cnt[0]);
            d[2*W +: W] = 8'(8'h30 + cnt[1]);
            ordy = c[0];
            #2;
            if (c < 2) begin
                n_checks++;
                if (ov !== (c == 1)) begin
                    n_fail++; $display("FAIL skid_latency[%0d]: got v=%b expected %b", c, ov, c == 1);
                end
            end
            if (ov && ordy) begin
                src_i = got % 2;
                es = src_i ? 2'd2 : 2'd0;
                ed = 8'((src_i ? 8'h30 : 8'h10) + got / 2);
                n_checks++;
                if (os !== es || od !== ed || ol !== 1'b1) begin
                    n_fail++; $display("FAIL skid_order[%0d]: got s=%0d d=%h l=%b expected %0d %h 1", got, os, od, ol, es, ed);
                end
                got++;
            end
            if (v[0] && in_rdy[0]) cnt[0]++;
            if (v[2] && in_rdy[2]) cnt[1]++;
            @(negedge clk);
        end
        n_checks++;
        if (got < 18) begin
            n_fail++; $display("FAIL skid_throughput: got %0d beats expected at least 18", got);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef STREAM_RR_ARBITER_OUT_REG_EN
        test_rr_single();
        test_lock_packet();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
`else
        test_skid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
